// File: rtl/demux12_pkg.sv
// Shared types and constants for the demux12_stream two-port demultiplexer.
package demux12_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned DEMUX12_CNT_W = 16;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/demux12_slot.sv
// One-entry register slice: holds a single word, drained by a valid/ready output handshake.
module demux12_slot
  import demux12_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_drain,
  output logic             o_can_load
);

  slot_state_e      r_state;
  slot_state_e      w_state_next;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  always_comb begin
    w_drain      = (r_state == FULL) && i_ready;
    w_state_next = r_state;
    // A load in the same cycle as a drain keeps the slot FULL with the new word.
    if (i_load) begin
      w_state_next = FULL;
    end else if (w_drain) begin
      w_state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_load) begin
        r_data <= i_load_data;
      end
    end
  end

  assign o_valid    = (r_state == FULL);
  assign o_data     = r_data;
  assign o_drain    = w_drain;
  assign o_can_load = (r_state == EMPTY) || i_ready;

endmodule

// File: rtl/demux12_stream.sv
// Valid/ready 1-to-2 stream demultiplexer with a one-entry slot per output port.
// Optional per-port delivered-word counters when DEMUX12_STREAM_COUNT_EN is defined.
module demux12_stream
  import demux12_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [WIDTH-1:0]         a_data,
`ifdef DEMUX12_STREAM_COUNT_EN
  output logic [DEMUX12_CNT_W-1:0] cnt_a,
  output logic [DEMUX12_CNT_W-1:0] cnt_b,
`endif
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [WIDTH-1:0]         b_data
);

  logic w_can_load_a;
  logic w_can_load_b;
  logic w_drain_a;
  logic w_drain_b;
  logic w_xfer;
  logic w_load_a;
  logic w_load_b;

  assign in_ready = !reset && ((in_sel == PORT_B) ? w_can_load_b : w_can_load_a);
  assign w_xfer   = in_valid && in_ready;
  assign w_load_a = w_xfer && (in_sel == PORT_A);
  assign w_load_b = w_xfer && (in_sel == PORT_B);

  demux12_slot #(
    .WIDTH (WIDTH)
  ) u_slot_a (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load_a),
    .i_load_data (in_data),
    .i_ready     (a_ready),
    .o_valid     (a_valid),
    .o_data      (a_data),
    .o_drain     (w_drain_a),
    .o_can_load  (w_can_load_a)
  );

  demux12_slot #(
    .WIDTH (WIDTH)
  ) u_slot_b (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load_b),
    .i_load_data (in_data),
    .i_ready     (b_ready),
    .o_valid     (b_valid),
    .o_data      (b_data),
    .o_drain     (w_drain_b),
    .o_can_load  (w_can_load_b)
  );

`ifdef DEMUX12_STREAM_COUNT_EN
  localparam logic [DEMUX12_CNT_W-1:0] CntOne = 1;

  logic [DEMUX12_CNT_W-1:0] r_cnt_a;
  logic [DEMUX12_CNT_W-1:0] r_cnt_b;

  // Reset takes priority, so a handshake in a reset cycle is never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_drain_a) r_cnt_a <= r_cnt_a + CntOne;
      if (w_drain_b) r_cnt_b <= r_cnt_b + CntOne;
    end
  end

  assign cnt_a = r_cnt_a;
  assign cnt_b = r_cnt_b;
`else
  logic w_unused_drain;
  assign w_unused_drain = w_drain_a ^ w_drain_b;
`endif

endmodule
